sva_event_collector: RTL and testbench
======================================

// Module: sva_event_collector
// PURPOSE
//  Reads the fail/cover event pulses produced by immediate-assertion sites (assert/assume
//  else-branches, cover pass-actions) and serializes them into one timestamped report
//  stream with a valid/ready handshake. Sits between the assertion-bearing RTL/TB and a
//  log sink or trace FIFO. Also keeps saturating totals and a sticky any-fail flag.
// PARAMETERS
//  NUM_SRC  4   number of assertion sites; each has one fail and one cover input
//  CNT_W    8   width of the saturating fail/cover totals
//  TS_W     16  width of the free-running timestamp counter
// PORTS
//  clk          in   1              single clock, all state on rising edge
//  rst_n        in   1              asynchronous, active-low reset
//  clr          in   1              synchronous clear of pending, counters, output
//  evt_fail     in   NUM_SRC        per-site fail pulse, sampled every cycle
//  evt_cover    in   NUM_SRC        per-site cover pulse, sampled every cycle
//  out_valid    out  1              report word valid
//  out_ready    in   1              sink accepts report when valid&ready
//  out_src      out  clog2(NUM_SRC) site index of report (min width 1)
//  out_kind     out  1              1 = fail, 0 = cover
//  out_ts       out  TS_W           timestamp of first captured event in slot
//  out_ovf      out  1              extra events on that slot were coalesced
//  fail_total   out  CNT_W          saturating count of all fail pulses
//  cover_total  out  CNT_W          saturating count of all cover pulses
//  any_fail     out  1              sticky: any fail pulse since reset/clr
// BEHAVIOUR
//  - Reset: all outputs 0, ts=0, all slot pending/ovf bits 0.
//  - ts: free-running, +1 per cycle, wraps 2^TS_W-1 -> 0; unaffected by clr.
//  - Slots: 2*NUM_SRC (fail[i], cover[i]), each holds pending, ts_cap, ovf.
//  - Capture: pulse on idle slot -> pending=1, ts_cap=ts (current cycle), ovf=0.
//    Pulse on pending slot not drained this cycle -> ovf=1, ts_cap unchanged.
//    Pulse on slot drained same cycle -> new capture (pending stays 1, ts_cap=ts, ovf=0).
//  - Arbitration: any pending fail slot beats every cover slot; round-robin within each
//    class, pointer advances past the granted index only on grant.
//  - Output register loads granted slot when !out_valid or (out_valid&out_ready);
//    loading clears that slot. With nothing pending, valid&ready -> out_valid=0.
//  - While out_valid&!out_ready all out_* fields held stable (no change, no drop).
//  - Latency: pulse in cycle t -> out_valid earliest in cycle t+2; throughput 1/cycle.
//  - Totals add popcount of the respective input vector each cycle, saturate at all-ones
//    (no wrap). any_fail set by any evt_fail bit.
//  - clr: pending/ovf/out_valid/totals/any_fail -> 0 next edge; events in clr cycle dropped;
//    RR pointers -> 0. clr wins over simultaneous capture and handshake.
//  - rst_n low mid-transfer: everything cleared immediately; an in-flight report is lost.
// TESTING
//  1 evt_fail[2] pulse at ts=5, out_ready=1 -> cycle t+2 out_valid, src=2, kind=1, ts=5,
//    ovf=0; fail_total=1, any_fail=1.
//  2 evt_cover[0] 3 pulses in cycles 10,11,12, out_ready=0 -> one report ts=10 ovf=1 held
//    stable until ready; cover_total=3.
//  3 evt_fail=4'b1111 and evt_cover=4'b1111 same cycle, ready=1 -> 8 reports back-to-back:
//    fail src 0,1,2,3 then cover 0,1,2,3.
//  4 CNT_W=8, 300 fail pulses -> fail_total sticks at 255; ts crossing 65535->0 wraps.
//  5 reports pending + out_valid high, assert clr -> next cycle out_valid=0, totals 0,
//    no stale reports afterward.
//  6 rst_n low asynchronously mid-stream -> outputs 0 before next edge; same-slot pulse
//    coincident with drain -> second report with new ts, ovf=0.

Source files
------------

// File: rtl/sva_event_collector.sv
// Collects per-site assertion fail/cover pulses into per-slot pending state and
// serializes them as timestamped reports (fail before cover, round-robin in class).

module sva_evt_slot #(
  parameter int TS_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_i,
  input  logic            pulse_i,
  input  logic            drain_i,
  input  logic [TS_W-1:0] ts_i,
  output logic            pend_o,
  output logic            ovf_o,
  output logic [TS_W-1:0] ts_o
);
  logic            pend_q, pend_d, ovf_q, ovf_d;
  logic [TS_W-1:0] ts_q, ts_d;

  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    ts_d   = ts_q;
    if (clr_i) begin
      pend_d = 1'b0;
      ovf_d  = 1'b0;
    end else if (pulse_i) begin
      // a slot being drained this cycle is free again, so the pulse is a fresh capture
      if (!pend_q || drain_i) begin
        pend_d = 1'b1;
        ovf_d  = 1'b0;
        ts_d   = ts_i;
      end else begin
        ovf_d  = 1'b1;
      end
    end else if (drain_i) begin
      pend_d = 1'b0;
      ovf_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
      ovf_q  <= 1'b0;
      ts_q   <= '0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      ts_q   <= ts_d;
    end
  end

  assign pend_o = pend_q;
  assign ovf_o  = ovf_q;
  assign ts_o   = ts_q;
endmodule

module sva_rr_pick #(
  parameter int N     = 4,
  parameter int SRC_W = 2
) (
  input  logic [N-1:0]     pend_i,
  input  logic [SRC_W-1:0] ptr_i,
  output logic             found_o,
  output logic [SRC_W-1:0] idx_o
);
  // Scan from farthest to nearest so the last hit is the first pending index at/after ptr.
  always_comb begin
    int j;
    found_o = 1'b0;
    idx_o   = '0;
    j       = 0;
    for (int k = N-1; k >= 0; k--) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (pend_i[j]) begin
        found_o = 1'b1;
        idx_o   = SRC_W'(j);
      end
    end
  end
endmodule

module sva_event_collector #(
  parameter  int NUM_SRC = 4,
  parameter  int CNT_W   = 8,
  parameter  int TS_W    = 16,
  localparam int SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic [NUM_SRC-1:0] evt_fail,
  input  logic [NUM_SRC-1:0] evt_cover,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SRC_W-1:0]   out_src,
  output logic               out_kind,
  output logic [TS_W-1:0]    out_ts,
  output logic               out_ovf,
  output logic [CNT_W-1:0]   fail_total,
  output logic [CNT_W-1:0]   cover_total,
  output logic               any_fail
);
  localparam int SUM_W = CNT_W + $clog2(NUM_SRC + 1);

  logic [TS_W-1:0]                ts_q;
  logic [NUM_SRC-1:0]             f_pend, c_pend, f_ovf, c_ovf, f_drain, c_drain;
  logic [NUM_SRC-1:0][TS_W-1:0]   f_ts, c_ts;
  logic                           f_found, c_found, load;
  logic [SRC_W-1:0]               f_idx, c_idx;
  logic [SRC_W-1:0]               f_ptr_q, f_ptr_d, c_ptr_q, c_ptr_d;
  logic                           vld_q, vld_d, kind_q, kind_d, ovf_q, ovf_d, any_q, any_d;
  logic [SRC_W-1:0]               src_q, src_d;
  logic [TS_W-1:0]                ots_q, ots_d;
  logic [CNT_W-1:0]               ftot_q, ftot_d, ctot_q, ctot_d;
  logic [SUM_W-1:0]               fsum, csum;

  genvar g;
  generate
    for (g = 0; g < NUM_SRC; g++) begin : g_slot
      sva_evt_slot #(.TS_W(TS_W)) u_fail (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .pulse_i(evt_fail[g]), .drain_i(f_drain[g]),
        .ts_i(ts_q), .pend_o(f_pend[g]), .ovf_o(f_ovf[g]), .ts_o(f_ts[g]));
      sva_evt_slot #(.TS_W(TS_W)) u_cover (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .pulse_i(evt_cover[g]), .drain_i(c_drain[g]),
        .ts_i(ts_q), .pend_o(c_pend[g]), .ovf_o(c_ovf[g]), .ts_o(c_ts[g]));
    end
  endgenerate

  sva_rr_pick #(.N(NUM_SRC), .SRC_W(SRC_W)) u_pick_fail (
    .pend_i(f_pend), .ptr_i(f_ptr_q), .found_o(f_found), .idx_o(f_idx));
  sva_rr_pick #(.N(NUM_SRC), .SRC_W(SRC_W)) u_pick_cover (
    .pend_i(c_pend), .ptr_i(c_ptr_q), .found_o(c_found), .idx_o(c_idx));

  function automatic logic [SRC_W-1:0] ptr_next(input logic [SRC_W-1:0] i);
    return (i == SRC_W'(NUM_SRC-1)) ? '0 : i + 1'b1;
  endfunction

  assign load = !vld_q || out_ready;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      f_drain[i] = load && f_found && (f_idx == SRC_W'(i));
      c_drain[i] = load && !f_found && c_found && (c_idx == SRC_W'(i));
    end
  end

  always_comb begin
    vld_d   = vld_q;
    src_d   = src_q;
    kind_d  = kind_q;
    ots_d   = ots_q;
    ovf_d   = ovf_q;
    f_ptr_d = f_ptr_q;
    c_ptr_d = c_ptr_q;
    any_d   = any_q | (|evt_fail);
    fsum    = SUM_W'(ftot_q) + SUM_W'($countones(evt_fail));
    csum    = SUM_W'(ctot_q) + SUM_W'($countones(evt_cover));
    ftot_d  = (fsum[SUM_W-1:CNT_W] != '0) ? '1 : fsum[CNT_W-1:0];
    ctot_d  = (csum[SUM_W-1:CNT_W] != '0) ? '1 : csum[CNT_W-1:0];
    if (load) begin
      vld_d = f_found || c_found;
      if (f_found) begin
        src_d   = f_idx;
        kind_d  = 1'b1;
        ots_d   = f_ts[f_idx];
        ovf_d   = f_ovf[f_idx];
        f_ptr_d = ptr_next(f_idx);
      end else if (c_found) begin
        src_d   = c_idx;
        kind_d  = 1'b0;
        ots_d   = c_ts[c_idx];
        ovf_d   = c_ovf[c_idx];
        c_ptr_d = ptr_next(c_idx);
      end
    end
    if (clr) begin
      vld_d   = 1'b0;
      src_d   = '0;
      kind_d  = 1'b0;
      ots_d   = '0;
      ovf_d   = 1'b0;
      f_ptr_d = '0;
      c_ptr_d = '0;
      any_d   = 1'b0;
      ftot_d  = '0;
      ctot_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q    <= '0;
      vld_q   <= 1'b0;
      src_q   <= '0;
      kind_q  <= 1'b0;
      ots_q   <= '0;
      ovf_q   <= 1'b0;
      f_ptr_q <= '0;
      c_ptr_q <= '0;
      any_q   <= 1'b0;
      ftot_q  <= '0;
      ctot_q  <= '0;
    end else begin
      ts_q    <= ts_q + 1'b1;
      vld_q   <= vld_d;
      src_q   <= src_d;
      kind_q  <= kind_d;
      ots_q   <= ots_d;
      ovf_q   <= ovf_d;
      f_ptr_q <= f_ptr_d;
      c_ptr_q <= c_ptr_d;
      any_q   <= any_d;
      ftot_q  <= ftot_d;
      ctot_q  <= ctot_d;
    end
  end

  assign out_valid   = vld_q;
  assign out_src     = src_q;
  assign out_kind    = kind_q;
  assign out_ts      = ots_q;
  assign out_ovf     = ovf_q;
  assign fail_total  = ftot_q;
  assign cover_total = ctot_q;
  assign any_fail    = any_q;
endmodule

// File: tb/tb_sva_event_collector.sv
// Directed + randomized bench for sva_event_collector with a slot-level reference model.

module tb_sva_event_collector;
  logic       clk, rst_n, clr, out_ready;
  logic [3:0] evt_fail, evt_cover;
  logic       out_valid, out_kind, out_ovf, any_fail;
  logic [1:0] out_src;
  logic [15:0] out_ts;
  logic [7:0] fail_total, cover_total;

  sva_event_collector #(.NUM_SRC(4), .CNT_W(8), .TS_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .evt_fail(evt_fail), .evt_cover(evt_cover),
    .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src), .out_kind(out_kind),
    .out_ts(out_ts), .out_ovf(out_ovf), .fail_total(fail_total), .cover_total(cover_total),
    .any_fail(any_fail));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  // reference state; kind index 1 = fail, 0 = cover
  bit m_pend[2][4];
  bit m_ovf[2][4];
  int m_cap[2][4];
  int m_ptr[2];
  bit m_vld, m_kind, m_oovf, m_any;
  int m_src, m_ots, m_ft, m_ct, ts_m;
  logic [2:0] acc_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ptr[k] = 0;
      for (int i = 0; i < 4; i++) begin m_pend[k][i] = 0; m_ovf[k][i] = 0; m_cap[k][i] = 0; end
    end
    m_vld = 0; m_kind = 0; m_oovf = 0; m_any = 0; m_src = 0; m_ots = 0; m_ft = 0; m_ct = 0; ts_m = 0;
  endtask

  task automatic model_edge();
    int gk, gi, j;
    bit ld, p;
    if (!rst_n) begin model_reset(); return; end
    if (clr) begin
      for (int k = 0; k < 2; k++) begin
        m_ptr[k] = 0;
        for (int i = 0; i < 4; i++) begin m_pend[k][i] = 0; m_ovf[k][i] = 0; end
      end
      m_vld = 0; m_any = 0; m_ft = 0; m_ct = 0;
      ts_m = (ts_m + 1) % 65536;
      return;
    end
    ld = !m_vld || out_ready;
    gk = -1; gi = -1;
    if (ld)
      for (int kd = 1; kd >= 0; kd--)
        for (int k = 0; k < 4; k++) begin
          j = (m_ptr[kd] + k) % 4;
          if (gi < 0 && m_pend[kd][j]) begin gk = kd; gi = j; end
        end
    if (ld) begin
      m_vld = (gi >= 0);
      if (gi >= 0) begin
        m_src = gi; m_kind = (gk == 1); m_ots = m_cap[gk][gi]; m_oovf = m_ovf[gk][gi];
        m_ptr[gk] = (gi + 1) % 4;
      end
    end
    for (int kd = 0; kd < 2; kd++)
      for (int i = 0; i < 4; i++) begin
        p = (kd == 1) ? evt_fail[i] : evt_cover[i];
        if (p) begin
          if (!m_pend[kd][i] || (kd == gk && i == gi)) begin
            m_pend[kd][i] = 1; m_cap[kd][i] = ts_m; m_ovf[kd][i] = 0;
          end else m_ovf[kd][i] = 1;
        end else if (kd == gk && i == gi) begin
          m_pend[kd][i] = 0; m_ovf[kd][i] = 0;
        end
      end
    m_ft = (m_ft + $countones(evt_fail) > 255) ? 255 : m_ft + $countones(evt_fail);
    m_ct = (m_ct + $countones(evt_cover) > 255) ? 255 : m_ct + $countones(evt_cover);
    if (|evt_fail) m_any = 1;
    ts_m = (ts_m + 1) % 65536;
  endtask

  task automatic check_model();
    chk("valid", out_valid, m_vld);
    if (m_vld) begin
      chk("src", out_src, m_src);
      chk("kind", out_kind, m_kind);
      chk("ts", out_ts, m_ots);
      chk("ovf", out_ovf, m_oovf);
    end
    chk("fail_total", fail_total, m_ft);
    chk("cover_total", cover_total, m_ct);
    chk("any_fail", any_fail, m_any);
  endtask

  task automatic step();
    if (out_valid && out_ready) acc_q.push_back({out_kind, out_src});
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic run_to_ts(input int target);
    int guard = 0;
    while (ts_m != target && guard < 70000) begin step(); guard++; end
    chk("ts_reach", ts_m, target);
  endtask

  initial begin
    int t0;
    rst_n = 1'b0; clr = 1'b0; out_ready = 1'b0; evt_fail = '0; evt_cover = '0;
    model_reset();
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_ts", out_ts, 0);
    chk("rst_ftot", fail_total, 0);
    chk("rst_any", any_fail, 0);
    step(); step();
    rst_n = 1'b1;

    // single fail report, latency 2
    out_ready = 1'b1;
    run_to_ts(5);
    evt_fail = 4'b0100; step(); evt_fail = '0; step();
    chk("t1_valid", out_valid, 1);
    chk("t1_src", out_src, 2);
    chk("t1_kind", out_kind, 1);
    chk("t1_ts", out_ts, 5);
    chk("t1_ovf", out_ovf, 0);
    chk("t1_ftot", fail_total, 1);
    chk("t1_any", any_fail, 1);
    step();

    // coalescing behind a stalled output
    out_ready = 1'b0;
    run_to_ts(9);
    evt_fail = 4'b0010; step(); evt_fail = '0;
    evt_cover = 4'b0001; step(); step(); step(); evt_cover = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_hold_src", out_src, 1);
      chk("t2_hold_kind", out_kind, 1);
    end
    out_ready = 1'b1; step();
    chk("t2_cov_kind", out_kind, 0);
    chk("t2_cov_ts", out_ts, 10);
    chk("t2_cov_ovf", out_ovf, 1);
    chk("t2_ctot", cover_total, 3);
    step();

    // all sites at once after clr resets pointers
    clr = 1'b1; step(); clr = 1'b0;
    acc_q.delete();
    evt_fail = 4'hF; evt_cover = 4'hF; step(); evt_fail = '0; evt_cover = '0;
    for (int i = 0; i < 10; i++) step();
    chk("t3_count", acc_q.size(), 8);
    for (int i = 0; i < 8 && i < acc_q.size(); i++)
      chk("t3_order", acc_q[i], (i < 4) ? (4 + i) : (i - 4));

    // saturation and timestamp wrap
    evt_fail = 4'b0001;
    for (int i = 0; i < 300; i++) step();
    evt_fail = '0; step();
    chk("t4_sat", fail_total, 255);
    run_to_ts(65535);
    evt_fail = 4'b1000; step(); evt_fail = '0;
    evt_cover = 4'b1000; step(); evt_cover = '0;
    chk("t4_ts_hi", out_ts, 65535);
    step();
    chk("t4_ts_wrap", out_ts, 0);
    step(); step();

    // clr with reports pending and output held
    out_ready = 1'b0;
    evt_fail = 4'b0011; step(); evt_fail = '0; step(); step();
    clr = 1'b1; step(); clr = 1'b0;
    chk("t5_valid", out_valid, 0);
    chk("t5_ftot", fail_total, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin step(); chk("t5_nostale", out_valid, 0); end

    // asynchronous reset mid-stream
    out_ready = 1'b0;
    evt_fail = 4'b0001; step(); step(); step(); evt_fail = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_arst_valid", out_valid, 0);
    chk("t6_arst_ftot", fail_total, 0);
    chk("t6_arst_any", any_fail, 0);
    model_reset();
    step(); step();
    rst_n = 1'b1;
    step();

    // pulse coincident with drain of the same slot
    out_ready = 1'b1;
    t0 = ts_m;
    evt_fail = 4'b0001; step(); step(); evt_fail = '0;
    chk("t6_first_ts", out_ts, t0);
    chk("t6_first_ovf", out_ovf, 0);
    step();
    chk("t6_second_valid", out_valid, 1);
    chk("t6_second_ts", out_ts, (t0 + 1) % 65536);
    chk("t6_second_ovf", out_ovf, 0);
    step();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      evt_fail  = 4'($urandom & $urandom & $urandom);
      evt_cover = 4'($urandom & $urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      clr       = ($urandom_range(0, 199) == 0);
      step();
    end
    evt_fail = '0; evt_cover = '0; clr = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
